// File: rtl/operand_seq_4_pkg.sv
// Shared definitions for the operand-entry front end: default sizes and FSM state encoding.
package operand_seq_4_pkg;

    localparam int unsigned N_DEF   = 3;
    localparam int unsigned DEB_DEF = 20;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

endpackage

// File: rtl/operand_seq_4_if.sv
// Bus between the operand sequencer and the combinational adder/subtractor stage.
interface operand_seq_4_if #(
    parameter int unsigned N = 3
) ();
    logic [N:0] arith_a;
    logic [N:0] arith_b;
    logic       arith_sub;
    logic [N:0] arith_res;
    logic       arith_cout;
    logic       arith_ovf;

    modport master (
        output arith_a, arith_b, arith_sub,
        input  arith_res, arith_cout, arith_ovf
    );

    modport slave (
        input  arith_a, arith_b, arith_sub,
        output arith_res, arith_cout, arith_ovf
    );
endinterface

// File: rtl/operand_seq_4_step_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and one-cycle pulse
// on each rising edge of the debounced level.
module step_debounce #(
    parameter int unsigned DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic step
);
    localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles of disagreement; toggle the level once the count would hit DEB_CYCLES.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded purely from flops, so the pulse is glitch-free.
    assign step = level_q & ~prev_q;

endmodule

// File: rtl/operand_seq_4.sv
// Sequential operand-entry front end: captures A then B on button steps, drives the
// external adder/subtractor and registers its result for display.
module operand_seq_4
    import operand_seq_4_pkg::*;
#(
    parameter int unsigned N          = N_DEF,
    parameter int unsigned DEB_CYCLES = DEB_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N:0]       sw,
    input  logic             op_sub,
    input  logic             btn_step,
    operand_seq_4_if.master  arith,
    output logic [N:0]       res,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             result_valid,
    output logic [1:0]       state
);
    logic step_pulse;

    step_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_step),
        .step   (step_pulse)
    );

    state_t     state_q, state_d;
    logic [N:0] a_q, a_d;
    logic [N:0] b_q, b_d;
    logic       op_q, op_d;
    logic [N:0] res_q, res_d;
    logic       cout_q, cout_d;
    logic       ovf_q, ovf_d;
    logic       valid_q, valid_d;

    // Next-state and capture logic; every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            S_A: begin
                if (step_pulse) begin
                    a_d     = sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (step_pulse) begin
                    b_d     = sw;
                    op_d    = op_sub;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = arith.arith_res;
                cout_d  = arith.arith_cout;
                ovf_d   = arith.arith_ovf;
                valid_d = 1'b1;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (step_pulse) begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign arith.arith_a   = a_q;
    assign arith.arith_b   = b_q;
    assign arith.arith_sub = op_q;
    assign res             = res_q;
    assign res_cout        = cout_q;
    assign res_ovf         = ovf_q;
    assign result_valid    = valid_q;
    assign state           = state_q;

endmodule

// File: tb/tb_operand_seq_4.sv
// Bench for operand_seq_4: external 4-bit add/sub stage plus directed and random entries.
module tb_operand_seq_4;
    localparam int unsigned N   = 3;
    localparam int          DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       op_sub;
    logic       btn_step;
    logic [3:0] res;
    logic       res_cout, res_ovf, result_valid;
    logic [1:0] state;

    int n_tests  = 0;
    int n_fail   = 0;
    int step_cnt = 0;
    int exp_state;

    operand_seq_4_if #(.N(N)) arith_if ();

    operand_seq_4 #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .op_sub       (op_sub),
        .btn_step     (btn_step),
        .arith        (arith_if),
        .res          (res),
        .res_cout     (res_cout),
        .res_ovf      (res_ovf),
        .result_valid (result_valid),
        .state        (state)
    );

    always #5 clk = ~clk;

    // External adder/subtractor stage: a + (sub ? two's complement of b : b)
    logic [3:0] b_neg, b_eff;
    logic [4:0] sum5;
    assign b_neg = ~arith_if.arith_b + 4'd1;
    assign b_eff = arith_if.arith_sub ? b_neg : arith_if.arith_b;
    assign sum5  = {1'b0, arith_if.arith_a} + {1'b0, b_eff};
    assign arith_if.arith_res  = sum5[3:0];
    assign arith_if.arith_cout = sum5[4];
    assign arith_if.arith_ovf  = arith_if.arith_sub
        ? ((arith_if.arith_a[3] != arith_if.arith_b[3]) && (sum5[3] != arith_if.arith_a[3]))
        : ((arith_if.arith_a[3] == arith_if.arith_b[3]) && (sum5[3] != arith_if.arith_a[3]));

    always @(posedge clk) if (dut.step_pulse === 1'b1) step_cnt <= step_cnt + 1;

    // Expected {ovf, cout, res} from integer arithmetic on the operand values
    function automatic logic [5:0] ref_op(input int a, input int b, input bit sub);
        int sa, sb, exact, r;
        bit c, o;
        sa    = (a > 7) ? a - 16 : a;
        sb    = (b > 7) ? b - 16 : b;
        exact = sub ? sa - sb : sa + sb;
        r     = sub ? (a - b + 16) % 16 : (a + b) % 16;
        c     = sub ? (b != 0 && a >= b) : (a + b > 15);
        o     = (exact < -8) || (exact > 7);
        return {o, c, 4'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic press(output int lat);
        btn_step = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dut.step_pulse === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("press_latency", 32'(lat), 32'(DEB + 2));
    endtask

    task automatic release_btn();
        btn_step = 1'b0;
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic do_op(input int a, input int b, input bit sub);
        int lat;
        logic [5:0] e;
        e = ref_op(a, b, sub);
        if (exp_state == 3) begin
            press(lat);
            @(negedge clk);
            chk("ret_state", 32'(state), 32'd0);
            chk("ret_valid", 32'(result_valid), 32'd0);
            release_btn();
        end
        sw = 4'(a);
        press(lat);
        @(negedge clk);
        chk("a_state", 32'(state), 32'd1);
        chk("a_capture", 32'(arith_if.arith_a), 32'(a));
        release_btn();
        sw = 4'($urandom);
        op_sub = 1'($urandom);
        repeat (2) @(negedge clk);
        chk("a_hold", 32'(arith_if.arith_a), 32'(a));
        sw = 4'(b);
        op_sub = sub;
        press(lat);
        @(negedge clk);
        chk("exec_state", 32'(state), 32'd2);
        chk("exec_valid", 32'(result_valid), 32'd0);
        sw = 4'($urandom);
        op_sub = 1'($urandom);
        @(negedge clk);
        chk("show_state", 32'(state), 32'd3);
        chk("show_valid", 32'(result_valid), 32'd1);
        chk("show_b", 32'(arith_if.arith_b), 32'(b));
        chk("show_sub", 32'(arith_if.arith_sub), 32'(sub));
        chk("res", 32'(res), 32'(e[3:0]));
        chk("res_cout", 32'(res_cout), 32'(e[4]));
        chk("res_ovf", 32'(res_ovf), 32'(e[5]));
        release_btn();
        exp_state = 3;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, snap;
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; sw = '0; op_sub = 1'b0; btn_step = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_arith_a", 32'(arith_if.arith_a), 32'd0);
        chk("rst_arith_b", 32'(arith_if.arith_b), 32'd0);
        chk("rst_arith_sub", 32'(arith_if.arith_sub), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        rst = 1'b0;
        exp_state = 0;
        repeat (2) @(negedge clk);

        do_op(5, 3, 1'b1);
        do_op(7, 8, 1'b1);
        do_op(6, 5, 1'b0);

        // Fourth press leaves the result display
        press(lat);
        @(negedge clk);
        chk("p4_valid", 32'(result_valid), 32'd0);
        chk("p4_state", 32'(state), 32'd0);
        chk("p4_res_held", 32'(res), 32'hB);
        release_btn();
        exp_state = 0;

        // Short bounces never produce a step
        snap = step_cnt;
        foreach (pat[i]) begin
            btn_step = pat[i];
            @(negedge clk);
        end
        btn_step = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        chk("bounce_pulses", 32'(step_cnt - snap), 32'd0);
        chk("bounce_state", 32'(state), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
        end

        // Asynchronous reset in the middle of entry
        press(lat);
        @(negedge clk);
        release_btn();
        sw = 4'd9;
        press(lat);
        @(negedge clk);
        chk("pre_rst_state", 32'(state), 32'd1);
        chk("pre_rst_a", 32'(arith_if.arith_a), 32'd9);
        btn_step = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_arith_a", 32'(arith_if.arith_a), 32'd0);
        chk("async_valid", 32'(result_valid), 32'd0);

        // Button held across reset release
        btn_step = 1'b1;
        sw = 4'hC;
        repeat (3) @(negedge clk);
        snap = step_cnt;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("held_pulse", 32'(dut.step_pulse), (k == DEB + 2) ? 32'd1 : 32'd0);
        end
        chk("held_pulse_count", 32'(step_cnt - snap), 32'd1);
        chk("held_state", 32'(state), 32'd1);
        chk("held_a", 32'(arith_if.arith_a), 32'hC);
        release_btn();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
